// File: rtl/pool_window_gen.sv
// 2x2 non-overlapping window generator over a raster pixel stream; optional signed max output under POOL_WINDOW_MAX_EN.
// Window registered 1 cycle after its bottom-right pixel is accepted; input stalls while an unconsumed window is held.
module pool_window_gen #(
  parameter int BITWIDTH   = 8,
  parameter int MAP_WIDTH  = 28,
  parameter int MAP_HEIGHT = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] a,
  output logic signed [BITWIDTH-1:0] b,
  output logic signed [BITWIDTH-1:0] c,
  output logic signed [BITWIDTH-1:0] d,
  output logic                       frame_done
`ifdef POOL_WINDOW_MAX_EN
  ,
  output logic signed [BITWIDTH-1:0] max_number
`endif
);

  localparam int CW = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1;
  localparam int RW = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col_even;
  logic signed [BITWIDTH-1:0]  line_buf [MAP_WIDTH];
  logic signed [BITWIDTH-1:0]  held;
  logic                        last_win;
  logic                        accept;
  logic                        odd_row;
  logic                        load;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign odd_row    = row[0];
  assign load       = accept && odd_row && col[0];
  assign col_even   = col & ~COL_ONE;
  // Pulse coincides with the consuming handshake of the frame's last window.
  assign frame_done = out_valid && out_ready && last_win;

  // Top row of each window pair; contents need no reset since every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept && !odd_row) begin
      line_buf[col] <= in_data;
    end
  end

`ifdef POOL_WINDOW_MAX_EN
  logic signed [BITWIDTH-1:0] top_max;
  logic signed [BITWIDTH-1:0] bot_max;
  logic signed [BITWIDTH-1:0] win_max;

  always_comb begin
    top_max = (line_buf[col_even] > line_buf[col]) ? line_buf[col_even] : line_buf[col];
    bot_max = (held > in_data) ? held : in_data;
    win_max = (top_max > bot_max) ? top_max : bot_max;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      held      <= '0;
      out_valid <= 1'b0;
      last_win  <= 1'b0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
`ifdef POOL_WINDOW_MAX_EN
      max_number <= '0;
`endif
    end else begin
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (odd_row && !col[0]) begin
          held <= in_data;
        end
      end

      // A new window may replace the one being consumed in the same cycle.
      if (load) begin
        a         <= line_buf[col_even];
        b         <= line_buf[col];
        c         <= held;
        d         <= in_data;
        last_win  <= (row == ROW_LAST) && (col == COL_LAST);
        out_valid <= 1'b1;
`ifdef POOL_WINDOW_MAX_EN
        max_number <= win_max;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomized and directed bench for pool_window_gen on a 4x4 map, checked against an image-level window model.
module tb_pool_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] a, b, c, d;
  logic              frame_done;
`ifdef POOL_WINDOW_MAX_EN
  logic signed [7:0] max_number;
`endif

  pool_window_gen #(.BITWIDTH(8), .MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .c(c), .d(d),
    .frame_done(frame_done)
`ifdef POOL_WINDOW_MAX_EN
    , .max_number(max_number)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       w;
    logic signed [7:0] m;
    bit                last;
    int                acc;
  } exp_t;

  typedef struct {
    logic [31:0]       w;
    logic signed [7:0] m;
    bit                fd;
  } log_t;

  int                total = 0;
  int                bad   = 0;
  int                cyc   = 0;
  int                rdy_mode = 0;
  exp_t              exp_q[$];
  log_t              win_log[$];
  logic signed [7:0] img[NP];
  logic signed [7:0] fr[32];
  int                p = 0;
  bit                prev_vld = 0;
  bit                prev_hs  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] w4(input int wa, input int wb, input int wc, input int wd);
    return {8'(wa), 8'(wb), 8'(wc), 8'(wd)};
  endfunction

  function automatic logic signed [7:0] max4(input logic signed [7:0] x0, input logic signed [7:0] x1,
                                             input logic signed [7:0] x2, input logic signed [7:0] x3);
    logic signed [7:0] m;
    m = x0;
    if (x1 > m) m = x1;
    if (x2 > m) m = x2;
    if (x3 > m) m = x3;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard: the model knows only the image and the pixel position of each accept.
  always @(negedge clk) begin
    exp_t h;
    bit   hs;
    int   r, cc;
    if (!rst_n) begin
      total++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || {a, b, c, d} !== 32'h0) begin
        bad++;
        $display("FAIL reset_outs: got vld=%b fd=%b win=%h want 0 0 0", out_valid, frame_done, {a, b, c, d});
      end
      exp_q.delete();
      p = 0;
      prev_vld = 0;
      prev_hs  = 0;
    end else begin
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      hs = out_valid && out_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_window: got %h want none", {a, b, c, d});
        end else begin
          h = exp_q[0];
          total++;
          if ({a, b, c, d} !== h.w) begin
            bad++;
            $display("FAIL window: got %h want %h", {a, b, c, d}, h.w);
          end
          if (!prev_vld || prev_hs) begin
            total++;
            if (cyc != h.acc + 1) begin
              bad++;
              $display("FAIL latency: got cycle %0d want %0d", cyc, h.acc + 1);
            end
          end
          total++;
          if (frame_done !== (hs && h.last)) begin
            bad++;
            $display("FAIL frame_done: got %b want %b", frame_done, hs && h.last);
          end
`ifdef POOL_WINDOW_MAX_EN
          total++;
          if (max_number !== h.m) begin
            bad++;
            $display("FAIL max_number: got %0d want %0d", max_number, h.m);
          end
`endif
          if (hs) begin
            log_t l;
            l.w  = {a, b, c, d};
`ifdef POOL_WINDOW_MAX_EN
            l.m  = max_number;
`else
            l.m  = 8'sd0;
`endif
            l.fd = frame_done;
            win_log.push_back(l);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        total++;
        if (frame_done !== 1'b0) begin
          bad++;
          $display("FAIL frame_done_idle: got %b want 0", frame_done);
        end
      end
      prev_vld = out_valid;
      prev_hs  = hs;

      if (in_valid && in_ready) begin
        exp_t e;
        r  = p / W;
        cc = p % W;
        img[p] = in_data;
        if ((r % 2 == 1) && (cc % 2 == 1)) begin
          e.w    = {img[p-W-1], img[p-W], img[p-1], in_data};
          e.m    = max4(img[p-W-1], img[p-W], img[p-1], in_data);
          e.last = (p == NP - 1);
          e.acc  = cyc;
          exp_q.push_back(e);
        end
        p = (p + 1) % NP;
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, other = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3, 0) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_n(input int n, input int maxgap);
    int  g;
    bit  acc, ok;
    for (int i = 0; i < n; i++) begin
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = fr[i];
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) begin ok = 1; break; end
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no accept want accept of pixel %0d", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic fill_seq(input int start);
    for (int i = 0; i < 32; i++) fr[i] = 8'(start + i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base, fds;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Plain 1..16 frame with a permanently ready sink.
    rdy_mode = 0;
    fill_seq(1);
    base = win_log.size();
    send_n(16, 0);
    drain();
    chk("t1_count", 32'(win_log.size() - base), 32'd4);
    if (win_log.size() >= base + 4) begin
      chk("t1_w0", win_log[base].w,   w4(1, 2, 5, 6));
      chk("t1_w1", win_log[base+1].w, w4(3, 4, 7, 8));
      chk("t1_w2", win_log[base+2].w, w4(9, 10, 13, 14));
      chk("t1_w3", win_log[base+3].w, w4(11, 12, 15, 16));
      chk("t1_fd_first", 32'(win_log[base].fd), 32'd0);
      chk("t1_fd_last", 32'(win_log[base+3].fd), 32'd1);
    end

    // Downstream stall while the first window is waiting.
    rdy_mode = 2;
    base = win_log.size();
    fork
      send_n(16, 0);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        repeat (5) @(negedge clk);
        chk("t2_stall_ready", 32'(in_ready), 32'd0);
        chk("t2_stall_window", {a, b, c, d}, w4(1, 2, 5, 6));
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();
    chk("t2_count", 32'(win_log.size() - base), 32'd4);
    if (win_log.size() >= base + 4) begin
      chk("t2_w0", win_log[base].w,   w4(1, 2, 5, 6));
      chk("t2_w3", win_log[base+3].w, w4(11, 12, 15, 16));
    end

    // Signed values pass through untouched.
    for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(255, 0));
    fr[0] = -8'sd1;
    fr[1] = -8'sd2;
    fr[4] = -8'sd4;
    fr[5] = -8'sd3;
    base = win_log.size();
    send_n(16, 1);
    drain();
    if (win_log.size() > base) begin
      chk("t3_signed_w0", win_log[base].w, w4(-1, -2, -4, -3));
`ifdef POOL_WINDOW_MAX_EN
      chk("t3_signed_max", 32'(win_log[base].m), 32'(-8'sd1));
`endif
    end

    // Reset mid-frame, then a clean frame.
    fill_seq(1);
    send_n(7, 0);
    rst_n = 1'b0;
    #1;
    chk("t4_reset_vld", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = win_log.size();
    @(negedge clk);
    chk("t4_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_n(16, 0);
    drain();
    chk("t4_count", 32'(win_log.size() - base), 32'd4);
    if (win_log.size() >= base + 4) begin
      chk("t4_w0", win_log[base].w,   w4(1, 2, 5, 6));
      chk("t4_w3", win_log[base+3].w, w4(11, 12, 15, 16));
    end

    // Two frames back to back with no idle cycle.
    fill_seq(1);
    base = win_log.size();
    send_n(32, 0);
    drain();
    chk("t5_count", 32'(win_log.size() - base), 32'd8);
    if (win_log.size() >= base + 8) begin
      chk("t5_f2_w0", win_log[base+4].w, w4(17, 18, 21, 22));
      chk("t5_f2_w3", win_log[base+7].w, w4(27, 28, 31, 32));
      fds = 0;
      for (int i = 0; i < 8; i++) fds += int'(win_log[base+i].fd);
      chk("t5_fd_pulses", 32'(fds), 32'd2);
    end

    // Max-pool corner values.
    for (int i = 0; i < 16; i++) fr[i] = 8'(i);
    fr[0] = 8'sd4;  fr[1] = 8'sd3;  fr[4] = -8'sd8; fr[5] = -8'sd6;
    fr[2] = 8'sd1;  fr[3] = 8'sd2;  fr[6] = 8'sd3;  fr[7] = 8'sd4;
    base = win_log.size();
    send_n(16, 0);
    drain();
    if (win_log.size() >= base + 2) begin
      chk("t6_w0", win_log[base].w,   w4(4, 3, -8, -6));
      chk("t6_w1", win_log[base+1].w, w4(1, 2, 3, 4));
`ifdef POOL_WINDOW_MAX_EN
      chk("t6_max0", 32'(win_log[base].m),   32'd4);
      chk("t6_max1", 32'(win_log[base+1].m), 32'd4);
`endif
    end

    // Random data, gaps and backpressure.
    rdy_mode = 1;
    base = win_log.size();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(255, 0));
      send_n(16, 3);
    end
    drain();
    rdy_mode = 0;
    chk("t7_count", 32'(win_log.size() - base), 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, signed pixel width.
REQ-002 SHALL have parameter MAP_WIDTH, default 28, feature-map columns; must be even, >= 2.
REQ-003 SHALL have parameter MAP_HEIGHT, default 28, feature-map rows; must be even, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data holds a pixel.
REQ-007 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-008 SHALL have port in_data  input  BITWIDTH  signed pixel, raster order (row-major, col 0 first).
REQ-009 SHALL have port out_valid  output  1  window a/b/c/d valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the window.
REQ-011 SHALL have ports a, b, c, d  output  BITWIDTH each  signed 2x2 window: a=top-left, b=top-right, c=bottom-left, d=bottom-right.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on the final window handshake of a frame.

Function
REQ-013 SHALL accept a pixel exactly on cycles where in_valid && in_ready.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL keep column counter (0..MAP_WIDTH-1) and row counter (0..MAP_HEIGHT-1), advanced per accepted pixel; column wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
REQ-016 SHALL store every accepted pixel of an even row into a MAP_WIDTH-entry line buffer at the column index.
REQ-017 SHALL, on an odd row, hold each even-column pixel in a register for pairing.
REQ-018 SHALL, on accepting an odd-row odd-column pixel, register a=buf[col-1], b=buf[col], c=held pixel, d=accepted pixel, and assert out_valid on the next cycle (latency 1).
REQ-019 SHALL hold out_valid and a..d stable until out_valid && out_ready.
REQ-020 SHALL clear out_valid on handshake unless a new window is loaded in the same cycle, in which case out_valid stays 1 with the new window.
REQ-021 SHALL emit (MAP_WIDTH/2)*(MAP_HEIGHT/2) windows per frame, in raster order of window position.
REQ-022 SHALL pulse frame_done for one cycle on the handshake of the window whose d is pixel (MAP_HEIGHT-1, MAP_WIDTH-1).
REQ-023 SHALL pass values unmodified (no saturation or sign change); back-to-back frames need no idle cycle.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, frame_done=0, a=b=c=d=0, counters=0, held register=0, regardless of clk.
REQ-025 SHALL leave line-buffer contents unspecified after reset; they are rewritten before use.
REQ-026 SHALL, on reset mid-frame, discard the partial frame and treat the first pixel after reset release as (row 0, col 0).
REQ-027 SHALL drive in_ready=1 the first cycle after reset release.

Configuration
REQ-028 SHALL, with macro POOL_WINDOW_MAX_EN defined, add output max_number (BITWIDTH, signed) = signed maximum of a,b,c,d, registered with the same timing/validity as a..d, reset value 0.
REQ-029 SHALL, without POOL_WINDOW_MAX_EN, omit max_number and all comparison logic; a..d behaviour identical.

Verification
REQ-030 SHALL cover: MAP_WIDTH=MAP_HEIGHT=4, pixels 1..16, out_ready=1 -> windows (1,2,5,6),(3,4,7,8),(9,10,13,14),(11,12,15,16), each 1 cycle after d accepted; frame_done with last.
REQ-031 SHALL cover: same stream, out_ready=0 for 5 cycles while first window valid -> window (1,2,5,6) held stable, in_ready=0, no pixel lost; remaining windows correct.
REQ-032 SHALL cover: 4x4 stream with signed values -1,-2,-4,-3 at window-0 positions -> a=-1,b=-2,c=-4,d=-3 exactly; with POOL_WINDOW_MAX_EN max_number=-1.
REQ-033 SHALL cover: rst_n low after 7 pixels of a 4x4 frame, then fresh 1..16 -> out_valid=0 during reset, then the four windows of REQ-030 only.
REQ-034 SHALL cover: two back-to-back 4x4 frames (1..16 then 17..32), in_valid held 1 -> 8 windows, second frame first window (17,18,21,22), two frame_done pulses.
REQ-035 SHALL cover: with POOL_WINDOW_MAX_EN, window (4,3,-8,-6) -> max_number=4; (1,2,3,4) -> 4.
